// File: rtl/tag_store_pkg.sv
// Shared types and sizing helpers for the cache tag store.
// Optional write-to-read bypass: define TAG_STORE_BYPASS_EN.
package tag_store_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } ts_state_e;

    localparam int TAG_W_DEF = 23;
    localparam int SETS_DEF  = 16;
    localparam int WAYS_DEF  = 4;

    function automatic int set_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int entry_w(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage

// File: rtl/sram_1w1r_model.sv
// Generic 1W1R memory, per-way write mask, registered read.
// A read and write to the same address in one cycle returns old data.
module sram_1w1r_model #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WAYS  = 4,
    parameter int EW    = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WAYS-1:0]    wmask,
    input  logic [WAYS*EW-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [WAYS*EW-1:0] rdata
);

    logic [WAYS*EW-1:0] mem_q [DEPTH];
    logic [WAYS*EW-1:0] rd_data_d;
    logic [WAYS*EW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int w = 0; w < WAYS; w++) begin
                if (wmask[w]) begin
                    mem_q[waddr][w*EW +: EW] <= wdata[w*EW +: EW];
                end
            end
        end
    end

    // Read data holds when no read is issued.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/cache_tag_store.sv
// N-way, S-set tag store with init/flush sweep and 1-cycle hit lookup.
// Optional write-to-read bypass: define TAG_STORE_BYPASS_EN.
module cache_tag_store
    import tag_store_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 16,
    parameter int TAG_W = 23,
    localparam int SET_W = set_w(SETS),
    localparam int EW    = entry_w(TAG_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [SET_W-1:0]      lk_set,
    input  logic [TAG_W-1:0]      lk_tag,
    output logic                  rsp_valid,
    output logic [WAYS-1:0]       rsp_hit,
    output logic [WAYS*TAG_W-1:0] rsp_tags,
    output logic [WAYS-1:0]       rsp_vld,
    input  logic                  wr_en,
    input  logic [SET_W-1:0]      wr_set,
    input  logic [WAYS-1:0]       wr_way_mask,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  wr_vbit,
    input  logic                  flush_req,
    output logic                  busy
);

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    ts_state_e state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic lk_fire;
    logic wr_fire;
    logic mem_we;
    logic [SET_W-1:0] mem_waddr;
    logic [WAYS-1:0] mem_wmask;
    logic [WAYS*EW-1:0] mem_wdata;
    logic [WAYS*EW-1:0] mem_rdata;

    assign lk_fire = lk_valid && lk_ready;
    assign wr_fire = wr_en && lk_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lk_ready  = 1'b0;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_set;
        mem_wmask = wr_way_mask;
        mem_wdata = {WAYS{wr_vbit, wr_tag}};
        unique case (state_q)
            SWEEP: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wmask = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + SET_W'(1);
                if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                lk_ready = 1'b1;
                mem_we   = wr_en;
                if (flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    always_comb begin
        rsp_valid_d = lk_fire;
        tag_d       = lk_fire ? lk_tag : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SWEEP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            tag_q       <= tag_d;
        end
    end

    sram_1w1r_model #(
        .DEPTH (SETS),
        .AW    (SET_W),
        .WAYS  (WAYS),
        .EW    (EW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wmask (mem_wmask),
        .wdata (mem_wdata),
        .re    (lk_fire),
        .raddr (lk_set),
        .rdata (mem_rdata)
    );

`ifdef TAG_STORE_BYPASS_EN
    logic [WAYS-1:0] byp_mask_q, byp_mask_d;
    tag_entry_t byp_ent_q, byp_ent_d;

    // Capture same-set write alongside the lookup so the response can merge it.
    always_comb begin
        byp_mask_d = byp_mask_q;
        byp_ent_d  = byp_ent_q;
        if (lk_fire) begin
            byp_mask_d = (wr_fire && (wr_set == lk_set)) ? wr_way_mask : '0;
            byp_ent_d  = '{v: wr_vbit, tag: wr_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_mask_q <= '0;
            byp_ent_q  <= '0;
        end else begin
            byp_mask_q <= byp_mask_d;
            byp_ent_q  <= byp_ent_d;
        end
    end
`endif

    always_comb begin
        tag_entry_t ent;
        rsp_tags = '0;
        rsp_vld  = '0;
        rsp_hit  = '0;
        for (int w = 0; w < WAYS; w++) begin
            ent = tag_entry_t'(mem_rdata[w*EW +: EW]);
`ifdef TAG_STORE_BYPASS_EN
            if (byp_mask_q[w]) begin
                ent = byp_ent_q;
            end
`endif
            rsp_tags[w*TAG_W +: TAG_W] = ent.tag;
            rsp_vld[w] = ent.v;
            rsp_hit[w] = ent.v && (ent.tag == tag_q);
        end
    end

    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_cache_tag_store.sv
// Randomised and directed bench for cache_tag_store against a set/way model.
module tb_cache_tag_store;

    localparam int WAYS  = 4;
    localparam int SETS  = 16;
    localparam int TAG_W = 23;
    localparam int SET_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lk_valid = 1'b0;
    logic lk_ready;
    logic [SET_W-1:0] lk_set = '0;
    logic [TAG_W-1:0] lk_tag = '0;
    logic rsp_valid;
    logic [WAYS-1:0] rsp_hit;
    logic [WAYS*TAG_W-1:0] rsp_tags;
    logic [WAYS-1:0] rsp_vld;
    logic wr_en = 1'b0;
    logic [SET_W-1:0] wr_set = '0;
    logic [WAYS-1:0] wr_way_mask = '0;
    logic [TAG_W-1:0] wr_tag = '0;
    logic wr_vbit = 1'b0;
    logic flush_req = 1'b0;
    logic busy;

    cache_tag_store #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lk_valid    (lk_valid),
        .lk_ready    (lk_ready),
        .lk_set      (lk_set),
        .lk_tag      (lk_tag),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_tags    (rsp_tags),
        .rsp_vld     (rsp_vld),
        .wr_en       (wr_en),
        .wr_set      (wr_set),
        .wr_way_mask (wr_way_mask),
        .wr_tag      (wr_tag),
        .wr_vbit     (wr_vbit),
        .flush_req   (flush_req),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: plain arrays of valid bits and tags per set/way.
    bit               m_v   [SETS][WAYS];
    bit [TAG_W-1:0]   m_tag [SETS][WAYS];
    int               busy_left;
    bit               e_valid;
    bit [WAYS-1:0]    e_hit;
    bit [WAYS-1:0]    e_vld;
    bit [WAYS*TAG_W-1:0] e_tags;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w]   = 1'b0;
                m_tag[s][w] = '0;
            end
    endtask

    task automatic idle_inputs();
        lk_valid  = 1'b0;
        wr_en     = 1'b0;
        flush_req = 1'b0;
    endtask

    // One clock: check handshake, advance model at the edge, check response.
    task automatic tick();
        bit rdy;
        bit v;
        bit [TAG_W-1:0] t;
        rdy = (busy_left == 0);
        chk("busy", busy, !rdy);
        chk("lk_ready", lk_ready, rdy);
        @(posedge clk);
        if (rdy && lk_valid) begin
            e_valid = 1'b1;
            for (int w = 0; w < WAYS; w++) begin
                v = m_v[lk_set][w];
                t = m_tag[lk_set][w];
`ifdef TAG_STORE_BYPASS_EN
                if (wr_en && wr_set == lk_set && wr_way_mask[w]) begin
                    v = wr_vbit;
                    t = wr_tag;
                end
`endif
                e_vld[w] = v;
                e_tags[w*TAG_W +: TAG_W] = t;
                e_hit[w] = v && (t == lk_tag);
            end
        end else begin
            e_valid = 1'b0;
        end
        if (rdy && wr_en)
            for (int w = 0; w < WAYS; w++)
                if (wr_way_mask[w]) begin
                    m_v[wr_set][w]   = wr_vbit;
                    m_tag[wr_set][w] = wr_tag;
                end
        if (!rdy) begin
            busy_left--;
        end else if (flush_req) begin
            busy_left = SETS;
            m_clear();
        end
        #1;
        chk("rsp_valid", rsp_valid, e_valid);
        chk("rsp_hit", rsp_hit, e_hit);
        chk("rsp_vld", rsp_vld, e_vld);
        chk("rsp_tags", rsp_tags, e_tags);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        e_valid = 1'b0;
        e_hit = '0;
        e_vld = '0;
        e_tags = '0;
        busy_left = SETS;
        m_clear();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_hit", rsp_hit, '0);
        chk("rst_rsp_vld", rsp_vld, '0);
        chk("rst_rsp_tags", rsp_tags, '0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_lk_ready", lk_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input int s, input int m, input int t, input bit vb);
        wr_en = 1'b1;
        wr_set = SET_W'(s);
        wr_way_mask = WAYS'(m);
        wr_tag = TAG_W'(t);
        wr_vbit = vb;
    endtask

    task automatic do_look(input int s, input int t);
        lk_valid = 1'b1;
        lk_set = SET_W'(s);
        lk_tag = TAG_W'(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        apply_reset();
        // Init sweep: 16 busy cycles, lookups ignored meanwhile.
        do_look(5, 0);
        repeat (SETS) tick();
        tick();
        idle_inputs();
        tick();

        do_write(3, 4'b0100, 'h12345, 1'b1);
        tick();
        idle_inputs();
        do_look(3, 'h12345);
        tick();
        chk("hit_way2", rsp_hit, 4'b0100);
        chk("tag_way2", rsp_tags[2*TAG_W +: TAG_W], 'h12345);
        do_look(3, 'h12346);
        tick();
        chk("miss_tag", rsp_hit, 4'b0000);
        idle_inputs();
        tick();

        do_write(7, 4'b0001, 'h1, 1'b1);
        do_look(7, 'h1);
        tick();
`ifdef TAG_STORE_BYPASS_EN
        chk("same_cycle_byp", rsp_hit, 4'b0001);
`else
        chk("same_cycle_raw", rsp_hit, 4'b0000);
`endif
        idle_inputs();
        do_look(7, 'h1);
        tick();
        chk("after_write", rsp_hit, 4'b0001);
        idle_inputs();

        for (int s = 0; s < SETS; s += SETS - 1) begin
            for (int w = 0; w < WAYS; w++) begin
                do_write(s, 1 << w, 'h100 + s * 8 + w, 1'b1);
                tick();
            end
        end
        idle_inputs();
        do_look(15, 'h100 + 15 * 8 + 1);
        tick();
        idle_inputs();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        do_look(0, 'h100);
        repeat (SETS) tick();
        do_look(0, 'h100);
        tick();
        chk("flush_set0", rsp_vld, 4'b0000);
        do_look(15, 'h100 + 15 * 8);
        tick();
        chk("flush_set15", rsp_vld, 4'b0000);
        idle_inputs();

        do_write(2, 4'b1111, 'h7ab, 1'b1);
        tick();
        idle_inputs();
        do_look(2, 'h7ab);
        tick();
        idle_inputs();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (8) tick();
        apply_reset();
        repeat (SETS) tick();
        tick();

        for (int s = 1; s <= 3; s++) begin
            do_write(s, 4'b1000, 'h50 + s, 1'b1);
            tick();
        end
        idle_inputs();
        for (int s = 1; s <= 3; s++) begin
            do_look(s, 'h50 + s);
            tick();
            chk("b2b_hit", rsp_hit, 4'b1000);
        end
        idle_inputs();
        tick();

        for (int i = 0; i < 600; i++) begin
            lk_valid = ($urandom_range(0, 3) != 0);
            lk_set = SET_W'($urandom_range(0, 3));
            lk_tag = TAG_W'($urandom_range(0, 3));
            wr_en = ($urandom_range(0, 1) != 0);
            wr_set = $urandom_range(0, 1) ? lk_set : SET_W'($urandom_range(0, 3));
            wr_way_mask = WAYS'($urandom);
            wr_tag = TAG_W'($urandom_range(0, 3));
            wr_vbit = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
